// File: rtl/pu_or1k_ticktimer_pkg.sv
// Shared definitions for the multi-channel OR1K tick timer: timer modes,
// TTMR field positions and SPR offset decode helpers.
package pu_or1k_ticktimer_pkg;

    typedef enum logic [1:0] {
        DISABLED   = 2'b00,
        RESTART    = 2'b01,
        STOP       = 2'b10,
        CONTINUOUS = 2'b11
    } mode_e;

    localparam int TTMR_MODE_HI = 31;
    localparam int TTMR_MODE_LO = 30;
    localparam int TTMR_IE_BIT  = 29;
    localparam int TTMR_IP_BIT  = 28;

    localparam int          OFF_WIDTH = 11;
    localparam logic [10:0] OFF_TTPSR = 11'h040;

    function automatic logic [10:0] ttmr_offset(input int n);
        return 11'(2 * n);
    endfunction

    function automatic logic [10:0] ttcr_offset(input int n);
        return 11'(2 * n + 1);
    endfunction

endpackage

// File: rtl/pu_or1k_ticktimer_channel.sv
// One tick-timer channel: TTMR/TTCR registers, one-shot done flag and the
// match/event logic driven by the shared prescaler tick.
module pu_or1k_ticktimer_channel
    import pu_or1k_ticktimer_pkg::*;
#(
    parameter int CNT_WIDTH = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tick,
    input  logic        i_ttmr_we,
    input  logic        i_ttcr_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ttmr,
    output logic [31:0] o_ttcr,
    output logic        o_irq
);

    mode_e                r_mode;
    logic                 r_ie;
    logic                 r_ip;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_event;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 w_unused_wdata;

    assign w_event = i_tick && (r_mode != DISABLED) && (r_count == r_period) && !r_done;

    // A software write to TTMR overrides a same-cycle interrupt set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= DISABLED;
            r_ie     <= 1'b0;
            r_ip     <= 1'b0;
            r_period <= '0;
        end else if (i_ttmr_we) begin
            r_mode   <= mode_e'(i_wdata[TTMR_MODE_HI:TTMR_MODE_LO]);
            r_ie     <= i_wdata[TTMR_IE_BIT];
            r_ip     <= i_wdata[TTMR_IP_BIT];
            r_period <= i_wdata[CNT_WIDTH-1:0];
        end else if (w_event && r_ie) begin
            r_ip <= 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (i_ttcr_we) begin
            w_count_next = i_wdata[CNT_WIDTH-1:0];
        end else begin
            unique case (r_mode)
                DISABLED: w_count_next = r_count;
                RESTART: begin
                    if (w_event)     w_count_next = '0;
                    else if (i_tick) w_count_next = r_count + 1'b1;
                end
                STOP: begin
                    if (i_tick && !w_event && !r_done) w_count_next = r_count + 1'b1;
                end
                CONTINUOUS: begin
                    if (i_tick) w_count_next = r_count + 1'b1;
                end
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Only a one-shot (STOP) match latches done; any register write re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if (i_ttmr_we || i_ttcr_we) begin
            r_done <= 1'b0;
        end else if (w_event && (r_mode == STOP)) begin
            r_done <= 1'b1;
        end
    end

    always_comb begin
        o_ttmr                                = '0;
        o_ttmr[TTMR_MODE_HI:TTMR_MODE_LO]     = r_mode;
        o_ttmr[TTMR_IE_BIT]                   = r_ie;
        o_ttmr[TTMR_IP_BIT]                   = r_ip;
        o_ttmr[CNT_WIDTH-1:0]                 = r_period;
        o_ttcr                                = '0;
        o_ttcr[CNT_WIDTH-1:0]                 = r_count;
    end

    assign o_irq          = r_ip;
    assign w_unused_wdata = ^i_wdata;

endmodule

// File: rtl/pu_or1k_ticktimer_multi.sv
// Multi-channel OR1K tick timer: shared prescaler, SPR decode and read mux
// around NUM_TIMERS independent timer channels.
module pu_or1k_ticktimer_multi
    import pu_or1k_ticktimer_pkg::*;
#(
    parameter int NUM_TIMERS     = 4,
    parameter int CNT_WIDTH      = 28,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spr_access_i,
    input  logic                  spr_we_i,
    input  logic [15:0]           spr_addr_i,
    input  logic [31:0]           spr_dat_i,
    output logic                  spr_bus_ack,
    output logic [31:0]           spr_dat_o,
    output logic [NUM_TIMERS-1:0] irq_o,
    output logic                  irq_any_o
);

    logic [PRESCALE_WIDTH-1:0]       r_psr;
    logic [PRESCALE_WIDTH-1:0]       r_div;

    logic                            w_tick;
    logic                            w_wr;
    logic                            w_psr_we;
    logic [OFF_WIDTH-1:0]            w_off;
    logic [31:0]                     w_rdata;
    logic [NUM_TIMERS-1:0][31:0]     w_ttmr;
    logic [NUM_TIMERS-1:0][31:0]     w_ttcr;
    logic                            w_unused_addr;

    assign w_off         = spr_addr_i[OFF_WIDTH-1:0];
    assign w_wr          = spr_access_i && spr_we_i;
    assign w_psr_we      = w_wr && (w_off == OFF_TTPSR);
    assign w_tick        = (r_div == r_psr);
    assign w_unused_addr = ^spr_addr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psr <= '0;
        end else if (w_psr_we) begin
            r_psr <= spr_dat_i[PRESCALE_WIDTH-1:0];
        end
    end

    // Reloading the prescaler restarts the divide phase so the new ratio applies cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_psr_we || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        pu_or1k_ticktimer_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_ttmr_we (w_wr && (w_off == ttmr_offset(g))),
            .i_ttcr_we (w_wr && (w_off == ttcr_offset(g))),
            .i_wdata   (spr_dat_i),
            .o_ttmr    (w_ttmr[g]),
            .o_ttcr    (w_ttcr[g]),
            .o_irq     (irq_o[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_off == OFF_TTPSR) begin
            w_rdata[PRESCALE_WIDTH-1:0] = r_psr;
        end
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (w_off == ttmr_offset(i)) w_rdata = w_ttmr[i];
            if (w_off == ttcr_offset(i)) w_rdata = w_ttcr[i];
        end
    end

    assign spr_bus_ack = spr_access_i;
    assign spr_dat_o   = spr_access_i ? w_rdata : 32'h0;
    assign irq_any_o   = |irq_o;

endmodule

// File: tb/tb_pu_or1k_ticktimer_multi.sv
// Directed bench for the multi-channel tick timer with hand-computed
// counter, interrupt and register read-back expectations.
module tb_pu_or1k_ticktimer_multi;

    localparam int NT = 4;

    logic          clk;
    logic          rst_n;
    logic          spr_access_i;
    logic          spr_we_i;
    logic [15:0]   spr_addr_i;
    logic [31:0]   spr_dat_i;
    logic          spr_bus_ack;
    logic [31:0]   spr_dat_o;
    logic [NT-1:0] irq_o;
    logic          irq_any_o;

    int checks = 0;
    int passed = 0;

    pu_or1k_ticktimer_multi #(
        .NUM_TIMERS     (NT),
        .CNT_WIDTH      (8),
        .PRESCALE_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spr_access_i (spr_access_i),
        .spr_we_i     (spr_we_i),
        .spr_addr_i   (spr_addr_i),
        .spr_dat_i    (spr_dat_i),
        .spr_bus_ack  (spr_bus_ack),
        .spr_dat_o    (spr_dat_o),
        .irq_o        (irq_o),
        .irq_any_o    (irq_any_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [15:0] BASE  = 16'h5000;
    localparam logic [10:0] TTPSR = 11'h040;

    function automatic logic [10:0] ttmr(input int n);
        return 11'(2 * n);
    endfunction

    function automatic logic [10:0] ttcr(input int n);
        return 11'(2 * n + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spr_write(input logic [10:0] off, input logic [31:0] d);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b1;
        spr_addr_i   = BASE | {5'b0, off};
        spr_dat_i    = d;
        tick();
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
    endtask

    task automatic spr_read(input logic [10:0] off, output logic [31:0] d);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b0;
        spr_addr_i   = BASE | {5'b0, off};
        #1;
        d = spr_dat_o;
        spr_access_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq_o !== 4'b0 || irq_any_o !== 1'b0)
            $display("[TB] FAIL reset_irq: got irq_o=%b any=%b, want 0", irq_o, irq_any_o);
        else passed++;
        spr_read(ttmr(0), d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL reset_ttmr0: got %h want 0", d); else passed++;
        spr_read(TTPSR, d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL reset_ttpsr: got %h want 0", d); else passed++;
        spr_access_i = 1'b1;
        #1;
        checks++;
        if (spr_bus_ack !== 1'b1) $display("[TB] FAIL ack_high: got %b want 1", spr_bus_ack); else passed++;
        spr_access_i = 1'b0;
        #1;
        checks++;
        if (spr_bus_ack !== 1'b0) $display("[TB] FAIL ack_low: got %b want 0", spr_bus_ack); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] d;
        spr_write(11'h020, 32'hFFFF_FFFF);
        spr_read(11'h020, d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL unmapped_read: got %h want 0", d); else passed++;
        spr_read(11'h041, d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL unmapped_41: got %h want 0", d); else passed++;
    endtask

    task automatic test_restart();
        logic [31:0] d;
        spr_write(ttmr(0), 32'h6000_0005);
        spr_read(ttcr(0), d);
        checks++;
        if (d !== 32'd0) $display("[TB] FAIL restart_start: got %0d want 0", d); else passed++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            spr_read(ttcr(0), d);
            checks++;
            if (d !== 32'(k) || irq_o[0] !== 1'b0)
                $display("[TB] FAIL restart_count%0d: got cnt=%0d irq=%b want cnt=%0d irq=0", k, d, irq_o[0], k);
            else passed++;
        end
        tick();
        spr_read(ttcr(0), d);
        checks++;
        if (d !== 32'd0 || irq_o[0] !== 1'b1 || irq_any_o !== 1'b1)
            $display("[TB] FAIL restart_wrap: got cnt=%0d irq=%b any=%b want 0/1/1", d, irq_o[0], irq_any_o);
        else passed++;
        spr_read(ttmr(0), d);
        checks++;
        if (d !== 32'h7000_0005) $display("[TB] FAIL restart_ttmr: got %h want 70000005", d); else passed++;
        spr_write(ttmr(0), 32'h0);
        checks++;
        if (irq_any_o !== 1'b0) $display("[TB] FAIL restart_ipclr: got any=%b want 0", irq_any_o); else passed++;
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        spr_write(TTPSR, 32'd3);
        spr_read(TTPSR, d);
        checks++;
        if (d !== 32'd3) $display("[TB] FAIL psr_read: got %0d want 3", d); else passed++;
        spr_write(ttmr(1), 32'h4000_000A);
        for (int j = 0; j <= 11; j++) begin
            if (j > 0) tick();
            spr_read(ttcr(1), d);
            checks++;
            if (d !== 32'((j + 1) / 4))
                $display("[TB] FAIL psr_count%0d: got %0d want %0d", j, d, (j + 1) / 4);
            else passed++;
        end
        spr_read(ttmr(1), d);
        checks++;
        if (d !== 32'h4000_000A || irq_o[1] !== 1'b0)
            $display("[TB] FAIL psr_noip: got ttmr=%h irq=%b want 4000000a/0", d, irq_o[1]);
        else passed++;
        spr_write(ttmr(1), 32'h0);
        spr_write(TTPSR, 32'd0);
    endtask

    task automatic test_stop();
        logic [31:0] d;
        spr_write(ttmr(2), 32'hA000_0003);
        for (int k = 1; k <= 3; k++) begin
            tick();
            spr_read(ttcr(2), d);
            checks++;
            if (d !== 32'(k) || irq_o[2] !== 1'b0)
                $display("[TB] FAIL stop_count%0d: got cnt=%0d irq=%b want cnt=%0d irq=0", k, d, irq_o[2], k);
            else passed++;
        end
        tick();
        spr_read(ttmr(2), d);
        checks++;
        if (d !== 32'hB000_0003) $display("[TB] FAIL stop_ipset: got %h want b0000003", d); else passed++;
        repeat (3) tick();
        spr_read(ttcr(2), d);
        checks++;
        if (d !== 32'd3 || irq_o[2] !== 1'b1)
            $display("[TB] FAIL stop_hold: got cnt=%0d irq=%b want 3/1", d, irq_o[2]);
        else passed++;
        spr_write(ttmr(2), 32'h8000_0003);
        repeat (3) tick();
        spr_read(ttcr(2), d);
        checks++;
        if (d !== 32'd3 || irq_o[2] !== 1'b0)
            $display("[TB] FAIL stop_ipclr: got cnt=%0d irq=%b want 3/0", d, irq_o[2]);
        else passed++;
        spr_write(ttcr(2), 32'd0);
        spr_read(ttcr(2), d);
        checks++;
        if (d !== 32'd0) $display("[TB] FAIL stop_rearm: got %0d want 0", d); else passed++;
        repeat (3) tick();
        spr_read(ttcr(2), d);
        checks++;
        if (d !== 32'd3) $display("[TB] FAIL stop_rerun: got %0d want 3", d); else passed++;
        repeat (2) tick();
        spr_read(ttcr(2), d);
        checks++;
        if (d !== 32'd3) $display("[TB] FAIL stop_rehold: got %0d want 3", d); else passed++;
        spr_write(ttmr(2), 32'h0);
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        spr_write(ttcr(3), 32'd250);
        spr_write(ttmr(3), 32'hE000_0002);
        repeat (5) tick();
        spr_read(ttcr(3), d);
        checks++;
        if (d !== 32'd255) $display("[TB] FAIL cont_255: got %0d want 255", d); else passed++;
        tick();
        spr_read(ttcr(3), d);
        checks++;
        if (d !== 32'd0) $display("[TB] FAIL cont_wrap: got %0d want 0", d); else passed++;
        repeat (2) tick();
        checks++;
        if (irq_o[3] !== 1'b0) $display("[TB] FAIL cont_preip: got %b want 0", irq_o[3]); else passed++;
        tick();
        spr_read(ttcr(3), d);
        checks++;
        if (d !== 32'd3 || irq_o[3] !== 1'b1)
            $display("[TB] FAIL cont_ip1: got cnt=%0d irq=%b want 3/1", d, irq_o[3]);
        else passed++;
        spr_write(ttmr(3), 32'hE000_0002);
        repeat (254) tick();
        spr_read(ttcr(3), d);
        checks++;
        if (d !== 32'd2 || irq_o[3] !== 1'b0)
            $display("[TB] FAIL cont_lap: got cnt=%0d irq=%b want 2/0", d, irq_o[3]);
        else passed++;
        tick();
        checks++;
        if (irq_o[3] !== 1'b1) $display("[TB] FAIL cont_ip2: got %b want 1", irq_o[3]); else passed++;
        spr_read(ttcr(1), d);
        checks++;
        if (d !== 32'd3) $display("[TB] FAIL indep_ch1: got %0d want 3", d); else passed++;
        spr_write(ttmr(3), 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        spr_write(ttcr(0), 32'd0);
        spr_write(ttmr(0), 32'h6000_0003);
        repeat (3) tick();
        spr_write(ttmr(0), 32'h6000_0003);
        spr_read(ttmr(0), d);
        checks++;
        if (d !== 32'h6000_0003) $display("[TB] FAIL b2b_ipwin: got %h want 60000003", d); else passed++;
        spr_read(ttcr(0), d);
        checks++;
        if (d !== 32'd0) $display("[TB] FAIL b2b_restart: got %0d want 0", d); else passed++;
        repeat (3) tick();
        spr_write(ttcr(0), 32'd7);
        spr_read(ttcr(0), d);
        checks++;
        if (d !== 32'd7 || irq_o[0] !== 1'b1)
            $display("[TB] FAIL b2b_ttcr7: got cnt=%0d irq=%b want 7/1", d, irq_o[0]);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        spr_write(TTPSR, 32'd2);
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq_o !== 4'b0 || irq_any_o !== 1'b0)
            $display("[TB] FAIL arst_irq: got irq_o=%b any=%b want 0", irq_o, irq_any_o);
        else passed++;
        spr_read(ttmr(0), d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL arst_ttmr0: got %h want 0", d); else passed++;
        spr_read(ttcr(0), d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL arst_ttcr0: got %h want 0", d); else passed++;
        spr_read(TTPSR, d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL arst_ttpsr: got %h want 0", d); else passed++;
        rst_n = 1'b1;
        tick();
        spr_write(ttmr(0), 32'h4000_00FF);
        tick();
        spr_read(ttcr(0), d);
        checks++;
        if (d !== 32'd1) $display("[TB] FAIL arst_restart: got %0d want 1", d); else passed++;
    endtask

    initial begin
        rst_n        = 1'b0;
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
        spr_addr_i   = 16'h0;
        spr_dat_i    = 32'h0;
        test_reset();
        test_decode();
        test_restart();
        test_prescale();
        test_stop();
        test_continuous();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
